// File: rtl/debounce_pkg.sv
// Shared types and default constants for the pushbutton debouncer.
package debounce_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } db_state_t;

  localparam int DB_SYNC_STAGES    = 2;
  localparam int DB_STABLE_SAMPLES = 4;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop metastability synchronizer for one asynchronous bit into the clk domain.
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a raw button and accepts a level change only after STABLE_SAMPLES
// consecutive divider strobes agree. Optional press-to-toggle output: DEBOUNCE_SYNC_TOGGLE_EN.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES    = DB_SYNC_STAGES,
  parameter int STABLE_SAMPLES = DB_STABLE_SAMPLES,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
`ifdef DEBOUNCE_SYNC_TOGGLE_EN
  ,
  output logic toggle_o
`endif
);

  localparam logic [CNT_W-1:0] LP_TARGET = CNT_W'(STABLE_SAMPLES);
  localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);

  logic             w_sync_b;
  logic             w_strobe;
  logic             w_differ;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_inc;

  logic             r_en_q;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  db_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;

  sync_2ff #(
    .STAGES(SYNC_STAGES)
  ) u_btn_sync (
    .clk(clk),
    .rst(rst),
    .i_d(btn_i),
    .o_q(w_sync_b)
  );

  // One strobe per divider period: rising edge of the toggling enable.
  assign w_strobe  = enable_i & ~r_en_q;
  assign w_differ  = (w_sync_b != r_level);
  assign w_cnt_inc = r_cnt + LP_ONE;
  assign w_accept  = w_strobe & w_differ &
                     (((r_state == STABLE) && (STABLE_SAMPLES == 1)) ||
                      ((r_state == CHECK) && (w_cnt_inc == LP_TARGET)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_q  <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_state <= STABLE;
      r_cnt   <= '0;
    end else begin
      r_en_q <= enable_i;
      r_rise <= w_accept & ~r_level;
      r_fall <= w_accept & r_level;
      if (w_accept) begin
        r_level <= ~r_level;
      end
      if (w_strobe) begin
        case (r_state)
          STABLE: begin
            if (w_differ) begin
              if (w_accept) begin
                r_cnt <= '0;
              end else begin
                r_cnt   <= LP_ONE;
                r_state <= CHECK;
              end
            end
          end
          CHECK: begin
            // A matching sample is a bounce: restart the count from scratch.
            if (!w_differ || w_accept) begin
              r_cnt   <= '0;
              r_state <= STABLE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= STABLE;
          end
        endcase
      end
    end
  end

`ifdef DEBOUNCE_SYNC_TOGGLE_EN
  logic r_toggle;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_toggle <= 1'b0;
    end else if (w_accept && !r_level) begin
      r_toggle <= ~r_toggle;
    end
  end

  assign toggle_o = r_toggle;
`endif

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;

endmodule
